// File: rtl/iterative_mul_div_unit_pkg.sv
// Shared types and decode helpers for the iterative multiply/divide unit.
// MulDivType keeps the execute-stage encoding: mul ops 0-3, div/rem ops 4-7.
package iterative_mul_div_unit_pkg;

    typedef enum logic [1:0] {
        IMD_IDLE = 2'd0,
        IMD_MUL  = 2'd1,
        IMD_DIV  = 2'd2,
        IMD_DONE = 2'd3
    } IterMulDivState;

    typedef enum logic [2:0] {
        MDT_MUL    = 3'd0,
        MDT_MULH   = 3'd1,
        MDT_MULHSU = 3'd2,
        MDT_MULHU  = 3'd3,
        MDT_DIV    = 3'd4,
        MDT_DIVU   = 3'd5,
        MDT_REM    = 3'd6,
        MDT_REMU   = 3'd7
    } MulDivType;

    function automatic logic isSignedSrc1(input MulDivType t);
        logic r;
        case (t)
            MDT_MUL, MDT_MULH, MDT_MULHSU, MDT_DIV, MDT_REM: r = 1'b1;
            default:                                         r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic isSignedSrc2(input MulDivType t);
        logic r;
        case (t)
            MDT_MUL, MDT_MULH, MDT_DIV, MDT_REM: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic isDivType(input MulDivType t);
        logic r;
        case (t)
            MDT_DIV, MDT_DIVU, MDT_REM, MDT_REMU: r = 1'b1;
            default:                              r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic isRemType(input MulDivType t);
        logic r;
        case (t)
            MDT_REM, MDT_REMU: r = 1'b1;
            default:           r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic isHighHalf(input MulDivType t);
        logic r;
        case (t)
            MDT_MULH, MDT_MULHSU, MDT_MULHU: r = 1'b1;
            default:                         r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/iterative_mul_div_unit_div_restoring_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// subtract the divisor when it fits and emit the matching quotient bit.
module div_restoring_step
    import iterative_mul_div_unit_pkg::*;
#(
    parameter int XLen = 32
) (
    input  logic [XLen:0]   rem_i,
    input  logic            bit_i,
    input  logic [XLen-1:0] divisor_i,
    output logic [XLen:0]   rem_o,
    output logic            qbit_o
);

    logic [XLen+1:0] shifted_s;
    logic [XLen+1:0] diff_s;

    assign shifted_s = {rem_i, bit_i};
    assign diff_s    = shifted_s - (XLen+2)'(divisor_i);
    assign qbit_o    = (shifted_s >= (XLen+2)'(divisor_i));
    // The restored remainder is always below 2*divisor, so XLen+1 bits hold it.
    assign rem_o     = (XLen+1)'(qbit_o ? diff_s : shifted_s);

endmodule

// File: rtl/iterative_mul_div_unit.sv
// Multi-cycle integer multiply/divide unit for the execute stage: radix-2^k
// shift-add multiplier, chained restoring divider, divide early-outs, stall and flush.
module iterative_mul_div_unit
    import iterative_mul_div_unit_pkg::*;
#(
    parameter int XLen            = 32,
    parameter int MulBitsPerCycle = 4,
    parameter int DivBitsPerCycle = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic            stall,
    input  logic            flush,
    input  logic [2:0]      mulDivType,
    input  logic [XLen-1:0] src1,
    input  logic [XLen-1:0] src2,
    output logic            done,
    output logic [XLen-1:0] result
);

    localparam int MulSteps = XLen / MulBitsPerCycle;
    localparam int DivSteps = XLen / DivBitsPerCycle;
    localparam int CntW     = $clog2(XLen + 1);
    localparam int PW       = XLen + MulBitsPerCycle;
    localparam logic [XLen-1:0] MostNeg = {1'b1, {(XLen-1){1'b0}}};

    if ((XLen != 32 && XLen != 64) || MulBitsPerCycle < 1 || DivBitsPerCycle < 1 ||
        (XLen % MulBitsPerCycle) != 0 || (XLen % DivBitsPerCycle) != 0) begin : g_param_check
        $error("iterative_mul_div_unit: illegal XLen / bits-per-cycle combination");
    end

    IterMulDivState    state_q, state_d;
    MulDivType         type_q, type_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2*XLen-1:0] prod_q, prod_d;
    logic [XLen-1:0]   mcand_q, mcand_d;
    logic [XLen:0]     rem_q, rem_d;
    logic [XLen-1:0]   dvd_q, dvd_d;
    logic              neg_q, neg_d;
    logic [XLen-1:0]   result_q, result_d;
    logic              done_q;

    MulDivType       op_s;
    logic            s1_neg_s, s2_neg_s;
    logic [XLen-1:0] mag1_s, mag2_s;
    logic            div_zero_s, div_ovf_s;

    assign op_s       = MulDivType'(mulDivType);
    assign s1_neg_s   = isSignedSrc1(op_s) & src1[XLen-1];
    assign s2_neg_s   = isSignedSrc2(op_s) & src2[XLen-1];
    assign mag1_s     = s1_neg_s ? (~src1 + {{(XLen-1){1'b0}}, 1'b1}) : src1;
    assign mag2_s     = s2_neg_s ? (~src2 + {{(XLen-1){1'b0}}, 1'b1}) : src2;
    assign div_zero_s = (src2 == {XLen{1'b0}});
    assign div_ovf_s  = isSignedSrc1(op_s) && (src1 == MostNeg) && (src2 == {XLen{1'b1}});

    // Multiplier: the low half of prod_q starts as the multiplier and is consumed
    // from the bottom while partial products accumulate into the top half.
    logic [MulBitsPerCycle-1:0] chunk_s;
    logic [PW-1:0]              partial_s, upper_s;
    logic [2*XLen-1:0]          prod_next_s, prod_fix_s;
    logic [XLen-1:0]            mul_res_s;

    assign chunk_s   = prod_q[MulBitsPerCycle-1:0];
    assign partial_s = PW'(mcand_q) * PW'(chunk_s);
    assign upper_s   = PW'(prod_q[2*XLen-1:XLen]) + partial_s;

    if (MulBitsPerCycle == XLen) begin : g_mul_full
        assign prod_next_s = upper_s;
    end else begin : g_mul_part
        assign prod_next_s = {upper_s, prod_q[XLen-1:MulBitsPerCycle]};
    end

    assign prod_fix_s = neg_q ? (~prod_next_s + {{(2*XLen-1){1'b0}}, 1'b1}) : prod_next_s;
    assign mul_res_s  = isHighHalf(type_q) ? prod_fix_s[2*XLen-1:XLen] : prod_fix_s[XLen-1:0];

    // Divider: dividend bits leave dvd_q at the top while quotient bits enter at the bottom.
    logic [XLen:0]          rem_chain_s [DivBitsPerCycle+1];
    logic [XLen-1:0]        dvd_chain_s [DivBitsPerCycle+1];
    logic [XLen-1:0]        quot_s, remv_s, div_res_s;

    assign rem_chain_s[0] = rem_q;
    assign dvd_chain_s[0] = dvd_q;

    for (genvar k = 0; k < DivBitsPerCycle; k++) begin : g_div_step
        logic qbit_s;
        div_restoring_step #(.XLen(XLen)) u_step (
            .rem_i     (rem_chain_s[k]),
            .bit_i     (dvd_chain_s[k][XLen-1]),
            .divisor_i (mcand_q),
            .rem_o     (rem_chain_s[k+1]),
            .qbit_o    (qbit_s)
        );
        assign dvd_chain_s[k+1] = {dvd_chain_s[k][XLen-2:0], qbit_s};
    end

    assign quot_s    = dvd_chain_s[DivBitsPerCycle];
    assign remv_s    = rem_chain_s[DivBitsPerCycle][XLen-1:0];
    assign div_res_s = isRemType(type_q)
                     ? (neg_q ? (~remv_s + {{(XLen-1){1'b0}}, 1'b1}) : remv_s)
                     : (neg_q ? (~quot_s + {{(XLen-1){1'b0}}, 1'b1}) : quot_s);

    // Next-state and datapath update for all four states.
    always_comb begin
        state_d  = state_q;
        type_d   = type_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        neg_d    = neg_q;
        result_d = result_q;
        case (state_q)
            IMD_IDLE: begin
                if (enable && !flush) begin
                    type_d = op_s;
                    neg_d  = isRemType(op_s) ? s1_neg_s : (s1_neg_s ^ s2_neg_s);
                    if (isDivType(op_s)) begin
                        if (div_zero_s) begin
                            result_d = isRemType(op_s) ? src1 : {XLen{1'b1}};
                            state_d  = IMD_DONE;
                        end else if (div_ovf_s) begin
                            result_d = isRemType(op_s) ? {XLen{1'b0}} : src1;
                            state_d  = IMD_DONE;
                        end else begin
                            mcand_d = mag2_s;
                            dvd_d   = mag1_s;
                            rem_d   = {(XLen+1){1'b0}};
                            cnt_d   = CntW'(DivSteps);
                            state_d = IMD_DIV;
                        end
                    end else begin
                        mcand_d = mag1_s;
                        prod_d  = {{XLen{1'b0}}, mag2_s};
                        cnt_d   = CntW'(MulSteps);
                        state_d = IMD_MUL;
                    end
                end else begin
                    state_d = IMD_IDLE;
                end
            end
            IMD_MUL: begin
                if (flush || !enable) begin
                    state_d = IMD_IDLE;
                end else begin
                    prod_d = prod_next_s;
                    cnt_d  = cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        result_d = mul_res_s;
                        state_d  = IMD_DONE;
                    end else begin
                        state_d = IMD_MUL;
                    end
                end
            end
            IMD_DIV: begin
                if (flush || !enable) begin
                    state_d = IMD_IDLE;
                end else begin
                    rem_d = rem_chain_s[DivBitsPerCycle];
                    dvd_d = dvd_chain_s[DivBitsPerCycle];
                    cnt_d = cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        result_d = div_res_s;
                        state_d  = IMD_DONE;
                    end else begin
                        state_d = IMD_DIV;
                    end
                end
            end
            IMD_DONE: begin
                if (flush) begin
                    state_d = IMD_IDLE;
                end else if (stall) begin
                    state_d = IMD_DONE;
                end else begin
                    state_d = IMD_IDLE;
                end
            end
            default: begin
                state_d = IMD_IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IMD_IDLE;
            type_q   <= MDT_MUL;
            cnt_q    <= {CntW{1'b0}};
            prod_q   <= {(2*XLen){1'b0}};
            mcand_q  <= {XLen{1'b0}};
            rem_q    <= {(XLen+1){1'b0}};
            dvd_q    <= {XLen{1'b0}};
            neg_q    <= 1'b0;
            result_q <= {XLen{1'b0}};
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            type_q   <= type_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            done_q   <= (state_d == IMD_DONE);
        end
    end

    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_iterative_mul_div_unit.sv
// Bench for iterative_mul_div_unit: directed table, random ops against an
// arithmetic reference, and cycle-exact sequences for stall/flush/abort/reset.
module tb_iterative_mul_div_unit;

    localparam logic [2:0] T_MUL = 3'd0, T_MULH = 3'd1, T_MULHSU = 3'd2, T_MULHU = 3'd3;
    localparam logic [2:0] T_DIV = 3'd4, T_DIVU = 3'd5, T_REM = 3'd6, T_REMU = 3'd7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        en32 = 1'b0, en64 = 1'b0;
    logic [2:0]  type32 = 3'd0, type64 = 3'd0;
    logic [31:0] a32 = '0, b32 = '0;
    logic [63:0] a64 = '0, b64 = '0;
    logic        done32, done64;
    logic [31:0] res32;
    logic [63:0] res64;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    iterative_mul_div_unit #(.XLen(32), .MulBitsPerCycle(4), .DivBitsPerCycle(1)) dut32 (
        .clk(clk), .rst(rst), .enable(en32), .stall(stall), .flush(flush),
        .mulDivType(type32), .src1(a32), .src2(b32), .done(done32), .result(res32)
    );

    iterative_mul_div_unit #(.XLen(64), .MulBitsPerCycle(8), .DivBitsPerCycle(2)) dut64 (
        .clk(clk), .rst(rst), .enable(en64), .stall(stall), .flush(flush),
        .mulDivType(type64), .src1(a64), .src2(b64), .done(done64), .result(res64)
    );

    typedef struct {
        bit          wide;
        logic [2:0]  t;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on sign/zero-extended operands.
    function automatic logic [31:0] model32(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] x, y, p;
        logic        ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        x = (t == T_MUL || t == T_MULH || t == T_MULHSU) ? {{32{a[31]}}, a} : {32'h0, a};
        y = (t == T_MUL || t == T_MULH) ? {{32{b[31]}}, b} : {32'h0, b};
        p = x * y;
        case (t)
            T_MUL:                     return p[31:0];
            T_MULH, T_MULHSU, T_MULHU: return p[63:32];
            T_DIV:  return (b == 32'h0) ? 32'hFFFF_FFFF : (ovf ? a : 32'($signed(a) / $signed(b)));
            T_DIVU: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            T_REM:  return (b == 32'h0) ? a : (ovf ? 32'h0 : 32'($signed(a) % $signed(b)));
            default: return (b == 32'h0) ? a : a % b;
        endcase
    endfunction

    function automatic int lat32(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b);
        if (t[2] && (b == 32'h0 || ((t == T_DIV || t == T_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        return t[2] ? 33 : 9;
    endfunction

    // Issue one op (enable first seen = cycle 0) and wait for done with a cycle budget.
    task automatic run_op(input bit wide, input logic [2:0] t, input logic [63:0] a, input logic [63:0] b,
                          output logic [63:0] res, output int cyc);
        @(negedge clk);
        if (wide) begin
            en64 = 1'b1; type64 = t; a64 = a; b64 = b;
        end else begin
            en32 = 1'b1; type32 = t; a32 = a[31:0]; b32 = b[31:0];
        end
        cyc = 0;
        res = '0;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (wide ? done64 : done32) begin
                res = wide ? res64 : {32'h0, res32};
                break;
            end
        end
        en32 = 1'b0;
        en64 = 1'b0;
    endtask

    vec_t        vecs[21];
    logic [63:0] res;
    int          cyc, first, second, ndone;
    logic [2:0]  rt;
    logic [31:0] ra, rb;

    initial begin
        vecs[0]  = '{0, T_MUL,    64'hFFFF_FFF9, 64'h2,         64'hFFFF_FFF2, 9};
        vecs[1]  = '{0, T_MUL,    64'h7,         64'hFFFF_FFFD, 64'hFFFF_FFEB, 9};
        vecs[2]  = '{0, T_MULH,   64'h8000_0000, 64'h8000_0000, 64'h4000_0000, 9};
        vecs[3]  = '{0, T_MULHSU, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 9};
        vecs[4]  = '{0, T_MULHU,  64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE, 9};
        vecs[5]  = '{0, T_DIV,    64'hFFFF_FFF9, 64'h2,         64'hFFFF_FFFD, 33};
        vecs[6]  = '{0, T_REM,    64'hFFFF_FFF9, 64'h2,         64'hFFFF_FFFF, 33};
        vecs[7]  = '{0, T_DIVU,   64'd100,       64'd7,         64'd14,        33};
        vecs[8]  = '{0, T_REMU,   64'd100,       64'd7,         64'd2,         33};
        vecs[9]  = '{0, T_DIV,    64'd5,         64'd0,         64'hFFFF_FFFF, 1};
        vecs[10] = '{0, T_REM,    64'd5,         64'd0,         64'd5,         1};
        vecs[11] = '{0, T_DIV,    64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, 1};
        vecs[12] = '{0, T_REM,    64'h8000_0000, 64'hFFFF_FFFF, 64'h0,         1};
        vecs[13] = '{0, T_DIVU,   64'h8000_0000, 64'hFFFF_FFFF, 64'h0,         33};
        vecs[14] = '{1, T_MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 9};
        vecs[15] = '{1, T_DIVU,   64'h8000_0000_0000_0000, 64'd3, 64'h2AAA_AAAA_AAAA_AAAA, 33};
        vecs[16] = '{1, T_REMU,   64'h8000_0000_0000_0000, 64'd3, 64'd2, 33};
        vecs[17] = '{1, T_DIV,    64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 33};
        vecs[18] = '{1, T_REM,    64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 33};
        vecs[19] = '{1, T_MULH,   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 9};
        vecs[20] = '{1, T_DIVU,   64'd9, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};

        repeat (2) @(negedge clk);
        chk("reset_done32", {63'h0, done32}, 64'h0);
        chk("reset_res32", {32'h0, res32}, 64'h0);
        chk("reset_done64", {63'h0, done64}, 64'h0);
        chk("reset_res64", res64, 64'h0);
        rst = 1'b0;

        for (int i = 0; i < 21; i++) begin
            run_op(vecs[i].wide, vecs[i].t, vecs[i].a, vecs[i].b, res, cyc);
            chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
            chk($sformatf("vec%0d_latency", i), 64'(cyc), 64'(vecs[i].lat));
        end

        for (int i = 0; i < 40; i++) begin
            rt = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 9))
                0: rb = 32'h0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 9));
                default: ;
            endcase
            run_op(1'b0, rt, {32'h0, ra}, {32'h0, rb}, res, cyc);
            chk($sformatf("rand%0d_t%0d_result", i, rt), res, {32'h0, model32(rt, ra, rb)});
            chk($sformatf("rand%0d_t%0d_latency", i, rt), 64'(cyc), 64'(lat32(rt, ra, rb)));
        end

        // Stall holds the finished result in Done for 3 extra cycles.
        @(negedge clk);
        stall = 1'b1; en32 = 1'b1; type32 = T_MUL; a32 = 32'd7; b32 = 32'hFFFF_FFFD;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done32 && cyc < 100);
        en32 = 1'b0;
        chk("stall_latency", 64'(cyc), 64'd9);
        chk("stall_result0", {32'h0, res32}, 64'hFFFF_FFEB);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk($sformatf("stall_done%0d", i), {63'h0, done32}, 64'h1);
            chk($sformatf("stall_result%0d", i), {32'h0, res32}, 64'hFFFF_FFEB);
            if (i == 3) stall = 1'b0;
        end
        @(negedge clk);
        chk("stall_release_done", {63'h0, done32}, 64'h0);

        // Back-to-back Mul ops with enable held high.
        @(negedge clk);
        en32 = 1'b1; type32 = T_MUL; a32 = 32'd3; b32 = 32'd5;
        cyc = 0; first = -1; second = -1;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done32) begin
                if (first < 0) begin
                    first = cyc;
                    chk("b2b_result1", {32'h0, res32}, 64'd15);
                    a32 = 32'd11; b32 = 32'd13;
                end else begin
                    second = cyc;
                    chk("b2b_result2", {32'h0, res32}, 64'd143);
                    break;
                end
            end
        end
        en32 = 1'b0;
        chk("b2b_first_cycle", 64'(first), 64'd9);
        chk("b2b_second_cycle", 64'(second), 64'd19);

        // Flush at cycle 10 of a Div with enable held: restart from Idle at cycle 11.
        @(negedge clk);
        en32 = 1'b1; type32 = T_DIV; a32 = 32'hFFFF_FFF9; b32 = 32'd2;
        cyc = 0; first = -1;
        while (cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (done32) begin
                first = cyc;
                break;
            end
            flush = (cyc == 10);
        end
        flush = 1'b0;
        en32 = 1'b0;
        chk("flush_done_cycle", 64'(first), 64'd44);
        chk("flush_restart_result", {32'h0, res32}, 64'hFFFF_FFFD);

        // Dropping enable mid-Mul aborts with no result.
        @(negedge clk);
        @(negedge clk);
        en32 = 1'b1; type32 = T_MUL; a32 = 32'd9; b32 = 32'd9;
        ndone = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done32) ndone++;
            if (i == 3) en32 = 1'b0;
        end
        chk("abort_done_count", 64'(ndone), 64'd0);
        chk("abort_result_kept", {32'h0, res32}, 64'hFFFF_FFFD);

        // Asynchronous reset mid-Mul clears outputs immediately.
        @(negedge clk);
        en32 = 1'b1; type32 = T_MUL; a32 = 32'd7; b32 = 32'd6;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_done32", {63'h0, done32}, 64'h0);
        chk("rst_res32", {32'h0, res32}, 64'h0);
        chk("rst_res64", res64, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        en32 = 1'b0;
        ndone = 0;
        repeat (15) begin
            @(negedge clk);
            if (done32) ndone++;
        end
        chk("rst_no_result", 64'(ndone), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/iterative_mul_div_unit.md
# iterative_mul_div_unit

Parametrised multi-cycle integer multiply/divide unit for the execute stage; successor to the fixed 32-bit, one-bit-per-cycle mul/div unit. Width, multiplier bits-per-cycle and divider bits-per-cycle are configurable. Adds divide special-case early-out, an explicit `stall` hold of the completed result, and flush/abort at any state. The execute stage holds `enable` while the op sits in EX and uses `!done` as its stall request.

## Interface
- `XLen`, 32: operand/result width (32 or 64).
- `MulBitsPerCycle`, 4: multiplier bits retired per compute cycle; must divide `XLen`.
- `DivBitsPerCycle`, 1: restoring-division steps unrolled per compute cycle; must divide `XLen`.
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `enable`  in  1  op present in EX and targets this unit.
- `stall`  in  1  downstream hold; keeps a finished result in `Done`.
- `flush`  in  1  kill current op.
- `mulDivType`  in  3  Mul, Mulh, Mulhsu, Mulhu, Div, Divu, Rem, Remu (existing `MulDivType` encoding).
- `src1`, `src2`  in  `XLen` each  rs1/rs2 values.
- `done`  out  1  result valid this cycle.
- `result`  out  `XLen`  registered result.

## Operation
- States: Idle, Mul, Div, Done. Reset: state Idle, `done`=0, `result`=0, counter 0, accumulators 0.
- Idle & `enable` & !`flush`: capture type and operand magnitudes (abs of signed operands per type), record result sign, load counter = `XLen/MulBitsPerCycle` (Mul) or `XLen/DivBitsPerCycle` (Div); go to Mul/Div.
- Div early-out in Idle: `src2`==0 -> quotient all-ones, remainder `src1`; signed `src1`==most-negative & `src2`==-1 -> quotient `src1`, remainder 0. Go straight to Done with result loaded.
- Mul: 2·`XLen` product register; each cycle add (multiplicand · next `MulBitsPerCycle` multiplier bits) shifted; decrement counter.
- Div: `DivBitsPerCycle` chained restoring steps per cycle on `XLen+1`-bit partial remainder; decrement counter.
- Counter reaching 0: apply sign fix-up (two's complement negate of 2·`XLen` product or of quotient/remainder), select low/high half or quotient/remainder, register into `result`, go to Done.
- Signs: Mulh both signed; Mulhsu src1 signed only; Div/Rem quotient negative iff signs differ, remainder takes dividend sign.
- Done: `done`=1. `stall` -> remain Done. Else -> Idle next cycle (a new op with `enable` starts from Idle, never directly from Done).
- `flush` any state -> Idle next cycle, `done`=0 in that next cycle; flush wins over `enable`. `enable` low in Mul/Div -> abort to Idle.

## Timing
- Enable first seen in Idle = cycle 0. Normal op: `done` at cycle N+1, N = `XLen`/bits-per-cycle. Defaults, XLen 32: Mul done cycle 9, Div/Rem done cycle 33.
- Div special case: `done` at cycle 1.
- `done` registered from state; `result` stable while `done`=1 (including across `stall`).
- Back-to-back ops: minimum one Idle cycle between Done and next capture.
- `rst` asserted mid-operation: immediate return to reset values, no result emitted.

## Structure
- Shared package: `IterMulDivState` enum, `MulDivType` (reused from OpTypes), helpers `isSignedSrc1/isSignedSrc2/isDivType/isHighHalf`.
- Sub-module `div_restoring_step`: one combinational restoring step (partial remainder, dividend bit, divisor -> new remainder, quotient bit); instantiated `DivBitsPerCycle` times via generate.
- Parameter legality checked by elaboration-time assertion.

## Test plan
- XLen 32, Mul 7 × -3 -> `done` at cycle 9, `result`=0xFFFFFFEB; Mulh 0x80000000 × 0x80000000 -> 0x40000000; Mulhsu -1 × 0xFFFFFFFF -> 0xFFFFFFFF; Mulhu same -> 0xFFFFFFFE.
- Div -7 / 2 -> -3 (0xFFFFFFFD), Rem -> -1, `done` at cycle 33; Divu 100/7 -> 14, Remu -> 2.
- Div 5 / 0 -> 0xFFFFFFFF, Rem 5 / 0 -> 5, Div 0x80000000 / -1 -> 0x80000000, Rem -> 0; all `done` at cycle 1.
- Finished op with `stall` held 3 cycles -> `done`=1 and `result` unchanged 4 cycles, then Idle; back-to-back Mul ops complete at cycles 9 and 19.
- `flush` at cycle 10 of a Div -> Idle at cycle 11, `done` never asserted; `rst` pulse mid-Mul -> `done`=0, `result`=0 immediately.
- XLen 64, MulBitsPerCycle 8, DivBitsPerCycle 2: Mulhu 0xFFFFFFFFFFFFFFFF² -> 0xFFFFFFFFFFFFFFFE at cycle 9; Divu 2^63/3 -> 0x2AAAAAAAAAAAAAAA at cycle 33.
